// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU control path: opcodes, T-state
// numbers, control-word bit positions and sequencer states.
`timescale 1ns/1ps
package cpu_pkg;

  // Opcodes as they appear in instruction register bits 7:4.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-states.
  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

  // Control-word bit positions. A set bit in an "active" word means the
  // signal is asserted, whatever its electrical polarity.
  localparam int CW_PC_INC       = 0;
  localparam int CW_PC_OUT       = 1;
  localparam int CW_N_PC_LOAD    = 2;
  localparam int CW_N_MAR_LOAD   = 3;
  localparam int CW_N_RAM_ENABLE = 4;
  localparam int CW_N_RAM_WRITE  = 5;
  localparam int CW_N_IR_LOAD    = 6;
  localparam int CW_N_IR_ENABLE  = 7;
  localparam int CW_N_A_LOAD     = 8;
  localparam int CW_A_OUT        = 9;
  localparam int CW_N_B_LOAD     = 10;
  localparam int CW_ALU_OUT      = 11;
  localparam int CW_ALU_SUB      = 12;
  localparam int CW_N_OUT_LOAD   = 13;
  localparam int CW_WIDTH        = 14;

  typedef logic [CW_WIDTH-1:0] cw_t;

  // One-hot word with only bit idx set.
  function automatic cw_t cw_bit(input int idx);
    cw_t one;
    one = {{(CW_WIDTH-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Bits whose pin is active-low; XOR with this turns "asserted" into pin levels.
  localparam cw_t CW_ACTIVE_LOW = cw_bit(CW_N_PC_LOAD)   | cw_bit(CW_N_MAR_LOAD)
                                | cw_bit(CW_N_RAM_ENABLE) | cw_bit(CW_N_RAM_WRITE)
                                | cw_bit(CW_N_IR_LOAD)    | cw_bit(CW_N_IR_ENABLE)
                                | cw_bit(CW_N_A_LOAD)     | cw_bit(CW_N_B_LOAD)
                                | cw_bit(CW_N_OUT_LOAD);

  // Sequencer run state: ARM holds T0 for the first edge after clear.
  typedef enum logic [1:0] {
    SEQ_ARM  = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_e;

  // Last T-state that does useful work for an opcode.
  function automatic logic [2:0] last_stage(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return T4;
      OP_ADD, OP_SUB: return T5;
      default:        return T3;
    endcase
  endfunction

endpackage

// File: rtl/step_counter.sv
// 3-bit T-state counter: async clear, synchronous wrap to 0, freeze hold.
`timescale 1ns/1ps
module step_counter (
  input  logic       clk,
  input  logic       clear,
  input  logic       wrap_i,
  input  logic       freeze_i,
  output logic [2:0] count_o
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  // Next count: freeze beats wrap, wrap beats increment.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    count_d = count_q;
    if (freeze_i) begin
      count_d = count_q;
    end else if (wrap_i) begin
      count_d = 3'd0;
    end else begin
      count_d = count_q + 3'd1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge clear) begin
    // NOTE: non-blocking (<=) so every flop samples pre-edge values together.
    if (clear) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: steps T-states and decodes (stage, opcode, run
// state) into every datapath control line.
`timescale 1ns/1ps
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       n_pc_load,
  output logic       n_mar_load,
  output logic       n_ram_enable,
  output logic       n_ram_write,
  output logic       n_ir_load,
  output logic       n_ir_enable,
  output logic       n_a_load,
  output logic       a_out,
  output logic       n_b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       n_out_load,
  output logic       halted,
  output logic [2:0] stage
);

  seq_state_e state_q;
  seq_state_e state_d;
  logic [2:0] stage_w;
  logic       hlt_now;
  logic       wrap;
  logic       freeze;
  cw_t        active;
  cw_t        cw;

  // HLT completes at its T3 edge.
  assign hlt_now = (state_q == SEQ_RUN) && (stage_w == T3) && (opcode == OP_HLT);

  // Run-state register; clear aborts any instruction and re-arms.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= SEQ_ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // Run-state transitions: arm for one edge, run, then halt until clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_ARM:  state_d = SEQ_RUN;
      SEQ_RUN:  if (hlt_now) state_d = SEQ_HALT;
      SEQ_HALT: state_d = SEQ_HALT;
      default:  state_d = SEQ_ARM;
    endcase
  end

  // Stage holds while arming or halted; wraps after the last useful stage
  // (or always at T5). Stages below T3 never match last_stage().
  assign freeze = (state_q != SEQ_RUN) || hlt_now;
  assign wrap   = (stage_w >= T5) || (EARLY_END && (stage_w >= last_stage(opcode)));

  step_counter u_step (
    .clk      (clk),
    .clear    (clear),
    .wrap_i   (wrap),
    .freeze_i (freeze),
    .count_o  (stage_w)
  );

  // Microcode: which signals are asserted for this stage and opcode.
  always_comb begin
    active = '0;
    if (state_q == SEQ_RUN) begin
      case (stage_w)
        T0: active = cw_bit(CW_PC_OUT) | cw_bit(CW_N_MAR_LOAD);
        T1: active = cw_bit(CW_PC_INC);
        T2: active = cw_bit(CW_N_RAM_ENABLE) | cw_bit(CW_N_IR_LOAD);
        T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA:
                    active = cw_bit(CW_N_IR_ENABLE) | cw_bit(CW_N_MAR_LOAD);
            OP_LDI: active = cw_bit(CW_N_IR_ENABLE) | cw_bit(CW_N_A_LOAD);
            OP_JMP: active = cw_bit(CW_N_IR_ENABLE) | cw_bit(CW_N_PC_LOAD);
            OP_OUT: active = cw_bit(CW_A_OUT) | cw_bit(CW_N_OUT_LOAD);
            default: active = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OP_LDA:         active = cw_bit(CW_N_RAM_ENABLE) | cw_bit(CW_N_A_LOAD);
            OP_ADD, OP_SUB: active = cw_bit(CW_N_RAM_ENABLE) | cw_bit(CW_N_B_LOAD);
            OP_STA:         active = cw_bit(CW_A_OUT) | cw_bit(CW_N_RAM_WRITE);
            default:        active = '0;
          endcase
        end
        T5: begin
          case (opcode)
            OP_ADD:  active = cw_bit(CW_ALU_OUT) | cw_bit(CW_N_A_LOAD);
            OP_SUB:  active = cw_bit(CW_ALU_OUT) | cw_bit(CW_N_A_LOAD) | cw_bit(CW_ALU_SUB);
            default: active = '0;
          endcase
        end
        default: active = '0;
      endcase
    end
  end

  // Convert asserted bits to pin levels.
  assign cw = active ^ CW_ACTIVE_LOW;

  assign pc_inc       = cw[CW_PC_INC];
  assign pc_out       = cw[CW_PC_OUT];
  assign n_pc_load    = cw[CW_N_PC_LOAD];
  assign n_mar_load   = cw[CW_N_MAR_LOAD];
  assign n_ram_enable = cw[CW_N_RAM_ENABLE];
  assign n_ram_write  = cw[CW_N_RAM_WRITE];
  assign n_ir_load    = cw[CW_N_IR_LOAD];
  assign n_ir_enable  = cw[CW_N_IR_ENABLE];
  assign n_a_load     = cw[CW_N_A_LOAD];
  assign a_out        = cw[CW_A_OUT];
  assign n_b_load     = cw[CW_N_B_LOAD];
  assign alu_out      = cw[CW_ALU_OUT];
  assign alu_sub      = cw[CW_ALU_SUB];
  assign n_out_load   = cw[CW_N_OUT_LOAD];
  assign halted       = (state_q == SEQ_HALT);
  assign stage        = stage_w;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: instance 0 runs EARLY_END=1, instance 1 EARLY_END=0.
// Drivers push the expected per-cycle response; monitors pop and compare.
`timescale 1ns/1ps
module tb_control_sequencer;
  import cpu_pkg::*;

  typedef struct {
    logic [2:0]  stage;
    logic [13:0] mask;
    logic        halted;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear        [2];
  logic [3:0] opcode       [2];
  logic       pc_inc       [2];
  logic       pc_out       [2];
  logic       n_pc_load    [2];
  logic       n_mar_load   [2];
  logic       n_ram_enable [2];
  logic       n_ram_write  [2];
  logic       n_ir_load    [2];
  logic       n_ir_enable  [2];
  logic       n_a_load     [2];
  logic       a_out        [2];
  logic       n_b_load     [2];
  logic       alu_out      [2];
  logic       alu_sub      [2];
  logic       n_out_load   [2];
  logic       halted       [2];
  logic [2:0] stage        [2];

  control_sequencer #(.EARLY_END(1'b1)) dut_early (
    .clk(clk), .clear(clear[0]), .opcode(opcode[0]),
    .pc_inc(pc_inc[0]), .pc_out(pc_out[0]), .n_pc_load(n_pc_load[0]),
    .n_mar_load(n_mar_load[0]), .n_ram_enable(n_ram_enable[0]),
    .n_ram_write(n_ram_write[0]), .n_ir_load(n_ir_load[0]),
    .n_ir_enable(n_ir_enable[0]), .n_a_load(n_a_load[0]), .a_out(a_out[0]),
    .n_b_load(n_b_load[0]), .alu_out(alu_out[0]), .alu_sub(alu_sub[0]),
    .n_out_load(n_out_load[0]), .halted(halted[0]), .stage(stage[0])
  );

  control_sequencer #(.EARLY_END(1'b0)) dut_full (
    .clk(clk), .clear(clear[1]), .opcode(opcode[1]),
    .pc_inc(pc_inc[1]), .pc_out(pc_out[1]), .n_pc_load(n_pc_load[1]),
    .n_mar_load(n_mar_load[1]), .n_ram_enable(n_ram_enable[1]),
    .n_ram_write(n_ram_write[1]), .n_ir_load(n_ir_load[1]),
    .n_ir_enable(n_ir_enable[1]), .n_a_load(n_a_load[1]), .a_out(a_out[1]),
    .n_b_load(n_b_load[1]), .alu_out(alu_out[1]), .alu_sub(alu_sub[1]),
    .n_out_load(n_out_load[1]), .halted(halted[1]), .stage(stage[1])
  );

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  exp_t sb_q0[$];
  exp_t sb_q1[$];

  task automatic check(input string name, input int g, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, g, $time, got, exp);
    end
  endtask

  // Observed asserted-signal word, polarity undone signal by signal.
  function automatic logic [13:0] act_mask(input int g);
    logic [13:0] m;
    m = '0;
    m[CW_PC_INC]       = pc_inc[g];
    m[CW_PC_OUT]       = pc_out[g];
    m[CW_N_PC_LOAD]    = ~n_pc_load[g];
    m[CW_N_MAR_LOAD]   = ~n_mar_load[g];
    m[CW_N_RAM_ENABLE] = ~n_ram_enable[g];
    m[CW_N_RAM_WRITE]  = ~n_ram_write[g];
    m[CW_N_IR_LOAD]    = ~n_ir_load[g];
    m[CW_N_IR_ENABLE]  = ~n_ir_enable[g];
    m[CW_N_A_LOAD]     = ~n_a_load[g];
    m[CW_A_OUT]        = a_out[g];
    m[CW_N_B_LOAD]     = ~n_b_load[g];
    m[CW_ALU_OUT]      = alu_out[g];
    m[CW_ALU_SUB]      = alu_sub[g];
    m[CW_N_OUT_LOAD]   = ~n_out_load[g];
    return m;
  endfunction

  function automatic logic [13:0] sig(input int idx);
    logic [13:0] one;
    one = 14'd1;
    return one << idx;
  endfunction

  // Reference microprogram: signals asserted at T-state t of opcode op.
  function automatic logic [13:0] exp_mask(input logic [3:0] op, input int t);
    logic [13:0] fetch [3];
    logic [13:0] rd;
    fetch[0] = sig(CW_PC_OUT) | sig(CW_N_MAR_LOAD);
    fetch[1] = sig(CW_PC_INC);
    fetch[2] = sig(CW_N_RAM_ENABLE) | sig(CW_N_IR_LOAD);
    rd = sig(CW_N_IR_ENABLE) | sig(CW_N_MAR_LOAD);
    if (t < 3) return fetch[t];
    if (op == 4'h1) return (t == 3) ? rd : (t == 4) ? (sig(CW_N_RAM_ENABLE) | sig(CW_N_A_LOAD)) : 14'd0;
    if (op == 4'h2 || op == 4'h3) begin
      if (t == 3) return rd;
      if (t == 4) return sig(CW_N_RAM_ENABLE) | sig(CW_N_B_LOAD);
      return sig(CW_ALU_OUT) | sig(CW_N_A_LOAD) | ((op == 4'h3) ? sig(CW_ALU_SUB) : 14'd0);
    end
    if (op == 4'h4) return (t == 3) ? rd : (t == 4) ? (sig(CW_A_OUT) | sig(CW_N_RAM_WRITE)) : 14'd0;
    if (t != 3) return 14'd0;
    if (op == 4'h5) return sig(CW_N_IR_ENABLE) | sig(CW_N_A_LOAD);
    if (op == 4'h6) return sig(CW_N_IR_ENABLE) | sig(CW_N_PC_LOAD);
    if (op == 4'hE) return sig(CW_A_OUT) | sig(CW_N_OUT_LOAD);
    return 14'd0;
  endfunction

  // Cycles taken by one instruction.
  function automatic int instr_len(input logic [3:0] op, input logic early);
    if (!early) return 6;
    if (op == 4'h1 || op == 4'h4) return 5;
    if (op == 4'h2 || op == 4'h3) return 6;
    return 4;
  endfunction

  task automatic push_exp(input int g, input int s, input logic [13:0] m, input logic h);
    exp_t e;
    e.stage  = 3'(s);
    e.mask   = m;
    e.halted = h;
    if (g == 0) sb_q0.push_back(e);
    else        sb_q1.push_back(e);
  endtask

  task automatic pop_exp(input int g, output exp_t e, output logic ok);
    ok = 1'b0;
    e.stage = '0; e.mask = '0; e.halted = 1'b0;
    if (g == 0 && sb_q0.size() > 0) begin e = sb_q0.pop_front(); ok = 1'b1; end
    if (g == 1 && sb_q1.size() > 0) begin e = sb_q1.pop_front(); ok = 1'b1; end
  endtask

  // Monitors: reset state while clear is high, scoreboard otherwise.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      logic ok;
      int   drivers;
      if (mon_en) begin
        if (clear[g]) begin
          check("rst_stage", g, 32'(stage[g]), 32'd0);
          check("rst_ctrl", g, 32'(act_mask(g)), 32'd0);
          check("rst_halted", g, 32'(halted[g]), 32'd0);
        end else begin
          pop_exp(g, e, ok);
          check("sb_has_entry", g, 32'(ok), 32'd1);
          if (ok) begin
            check("stage", g, 32'(stage[g]), 32'(e.stage));
            check("ctrl", g, 32'(act_mask(g)), 32'(e.mask));
            check("halted", g, 32'(halted[g]), 32'(e.halted));
          end
          drivers = int'(pc_out[g]) + int'(!n_ram_enable[g]) + int'(!n_ir_enable[g])
                  + int'(a_out[g]) + int'(alu_out[g]);
          check("one_bus_driver", g, 32'(drivers <= 1), 32'd1);
        end
      end
    end
  end

  // Release clear just after a sample; return one cycle into T0.
  task automatic do_release(input int g);
    repeat (2) @(negedge clk);
    #1 clear[g] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Assert clear mid-cycle and confirm it acts without a clock edge.
  task automatic do_clear(input int g);
    clear[g] = 1'b1;
    #1;
    check("clr_async_stage", g, 32'(stage[g]), 32'd0);
    check("clr_async_ctrl", g, 32'(act_mask(g)), 32'd0);
    check("clr_async_halted", g, 32'(halted[g]), 32'd0);
    if (g == 0) sb_q0.delete();
    else        sb_q1.delete();
  endtask

  // Run one instruction from its T0; stop>0 returns early at that stage.
  task automatic run_instr(input int g, input logic [3:0] op, input logic early, input int stop);
    int n;
    n = (stop == 0) ? instr_len(op, early) : stop;
    for (int t = 0; t < n; t++) push_exp(g, t, exp_mask(op, t), 1'b0);
    opcode[g] = op;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // HLT then a frozen halt of hold_cycles cycles.
  task automatic run_halt(input int g, input int hold_cycles);
    for (int t = 0; t < 4; t++) push_exp(g, t, exp_mask(4'hF, t), 1'b0);
    for (int i = 0; i < hold_cycles; i++) push_exp(g, 3, 14'd0, 1'b1);
    opcode[g] = 4'hF;
    repeat (4 + hold_cycles) @(posedge clk);
    #1;
  endtask

  task automatic seq_early();
    do_release(0);
    run_instr(0, 4'h1, 1'b1, 0);
    run_instr(0, 4'h1, 1'b1, 0);
    run_instr(0, 4'h3, 1'b1, 0);
    run_instr(0, 4'h3, 1'b1, 0);
    run_instr(0, 4'h6, 1'b1, 0);
    run_instr(0, 4'hE, 1'b1, 0);
    run_instr(0, 4'h4, 1'b1, 0);
    run_instr(0, 4'h5, 1'b1, 0);
    run_instr(0, 4'h2, 1'b1, 4);
    check("add_t4_word", 0, 32'(act_mask(0)), 32'(exp_mask(4'h2, 4)));
    do_clear(0);
    do_release(0);
    repeat (40) run_instr(0, 4'($urandom_range(14, 0)), 1'b1, 0);
    run_halt(0, 20);
    do_clear(0);
    do_release(0);
    run_instr(0, 4'h9, 1'b1, 0);
    run_instr(0, 4'h5, 1'b1, 0);
    do_clear(0);
  endtask

  task automatic seq_full();
    int cycles;
    cycles = 0;
    do_release(1);
    while (cycles < 1000) begin
      logic [3:0] op;
      op = 4'($urandom_range(14, 0));
      run_instr(1, op, 1'b0, 0);
      cycles += 6;
    end
    run_halt(1, 20);
    do_clear(1);
    do_release(1);
    run_instr(1, 4'h2, 1'b0, 0);
    do_clear(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear[0]  = 1'b1;
    clear[1]  = 1'b1;
    opcode[0] = 4'h0;
    opcode[1] = 4'h0;
    mon_en    = 1'b1;
    fork
      seq_early();
      seq_full();
    join
    @(negedge clk);
    mon_en = 1'b0;
    check("sb_drained", 0, 32'(sb_q0.size()), 32'd0);
    check("sb_drained", 1, 32'(sb_q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
